pipe_skid_reg: RTL

Two-entry elastic pipeline register with a valid/ready handshake on both sides, the consumer-side counterpart of the plain stage `Register`. It sits between pipeline stages of the processor datapath. It decouples an upstream producer from a downstream consumer that can stall, and sustains one transfer per cycle without a combinational ready path from output to input. A synchronous flush discards all held entries for branch/exception squash.

---
 rtl/pipe_skid_reg.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register: head register "main" feeds the consumer,
// "skid" absorbs the one entry that can arrive while the consumer stalls.
module pipe_skid_reg #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] EMPTY = 2'd0;
  localparam logic [SW-1:0] BUSY  = 2'd1;
  localparam logic [SW-1:0] FULL  = 2'd2;

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic [N-1:0]  main;
  logic [N-1:0]  skid;
  logic          push;
  logic          pop;
  logic          load_main;
  logic          main_from_skid;
  logic          load_skid;

  // Handshakes use the registered ready/valid only, so no comb path crosses the block.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Next-state and data-load decode
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_main = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Squash empties the buffer but leaves the stale payloads in place.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Payload registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main <= '0;
      skid <= '0;
    end else begin
      if (load_main) main <= main_from_skid ? skid : in_data;
      if (load_skid) skid <= in_data;
    end
  end

  assign out_data  = main;
  assign occupancy = state;

endmodule
